pl_imem_param: RTL
==================

PL_IMEM_PARAM -- requirements
Module: pl_imem_param

Interface
REQ-001 Parameter: AW, default 6, log2 of memory depth in 32-bit words (64 words).
REQ-002 Parameter: WAIT_CYC, default 0, extra wait cycles per fetch (range 0..7).
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: req  in  1  fetch request from IF stage.
REQ-006 Port: addr  in  32  byte address of fetch (PC).
REQ-007 Port: flush  in  1  cancel outstanding fetch (branch/exception redirect).
REQ-008 Port: ready  out  1  memory can accept a fetch this cycle.
REQ-009 Port: valid  out  1  inst/exc/exc_code valid this cycle (one-cycle pulse per fetch).
REQ-010 Port: inst  out  32  fetched instruction word.
REQ-011 Port: exc  out  1  fetch exception flag.
REQ-012 Port: exc_code  out  2  00 none, 01 misaligned, 10 out of range.
REQ-013 Port: we  in  1  program-load write enable.
REQ-014 Port: waddr  in  AW  word address of program-load write.
REQ-015 Port: wdata  in  32  program-load write data.

Function
REQ-016 Storage SHALL be 2^AW words x 32 bits, read word index addr[AW+1:2].
REQ-017 FSM SHALL have states IDLE, WAIT, RESP.
REQ-018 ready SHALL equal ~flush & ~rst & (state==IDLE | state==RESP); combinational.
REQ-019 Fetch accepted at edge where req & ready; accept latches word, exc, exc_code into output holding registers.
REQ-020 On accept: WAIT_CYC==0 -> RESP; else -> WAIT with counter loaded to WAIT_CYC-1.
REQ-021 WAIT: counter decrements each edge; at counter==0 -> RESP.
REQ-022 valid SHALL be 1 exactly when state==RESP; latency accept-edge to valid = 1+WAIT_CYC cycles.
REQ-023 RESP with no new accept -> IDLE; RESP with accept -> RESP/WAIT per REQ-020 (throughput 1 fetch/cycle when WAIT_CYC==0).
REQ-024 flush=1 at an edge: state -> IDLE, valid low next cycle, outstanding fetch discarded; no accept that edge.
REQ-025 Misaligned: addr[1:0]!=0 -> exc=1, exc_code=01.
REQ-026 Out of range: addr[31:AW+2]!=0 and aligned -> exc=1, exc_code=10; misaligned takes priority.
REQ-027 On exc, inst SHALL be 32'h00000000 (nop); valid timing unchanged.
REQ-028 Write: we=1 writes wdata to word waddr at edge; independent of FSM, allowed any state.
REQ-029 Write and accept same edge, same word: fetch returns old word (read-first).
REQ-030 inst/exc/exc_code SHALL hold last values while valid=0; consumers ignore them.

Reset
REQ-031 rst=1 at edge: state IDLE, counter 0, valid 0, inst 0, exc 0, exc_code 00.
REQ-032 rst mid-fetch (WAIT or RESP) discards fetch; no valid until new accept after rst deasserts.
REQ-033 rst SHALL NOT clear memory contents; write with rst=1 is ignored.

Verification
REQ-034 Load word 0x2008000f at waddr 0x1d, WAIT_CYC=0, req addr 0x74 -> valid 1 cycle later, inst 0x2008000f, exc 0.
REQ-035 WAIT_CYC=3, req addr 0x00 (word 0x0800001d) -> ready low 3 cycles, valid on 4th cycle after accept, single pulse.
REQ-036 WAIT_CYC=0, req held, addr 0x74,0x78,0x7c consecutive -> three consecutive valid cycles, words in order.
REQ-037 addr 0x76 -> exc 1, exc_code 01, inst 0; addr 0x100 (AW=6) -> exc 1, exc_code 10, inst 0.
REQ-038 WAIT_CYC=2, accept addr 0x74, flush 1 cycle later -> no valid; next req 0x84 returns word 0x21 normally.
REQ-039 we=1 waddr 0x1f wdata 0x0000000c at accept edge of addr 0x7c -> old word returned; refetch -> 0x0000000c; rst mid-WAIT -> no valid, memory retains 0x0000000c.

Source files
------------

// File: rtl/pl_imem_param.sv
// Instruction memory for the IF stage: word-addressed storage with a fixed-latency fetch FSM.
// Fetches are range- and alignment-checked; program-load writes bypass the FSM entirely.
module pl_imem_param #(
  parameter int AW       = 6,
  parameter int WAIT_CYC = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [31:0]   addr,
  input  logic          flush,
  output logic          ready,
  output logic          valid,
  output logic [31:0]   inst,
  output logic          exc,
  output logic [1:0]    exc_code,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] CNT_LOAD = (WAIT_CYC == 0) ? 3'd0 : 3'(WAIT_CYC - 1);

  logic [31:0]   mem [2**AW];
  state_t        state;
  logic [2:0]    cnt;

  logic [AW-1:0] idx;
  logic          misaligned;
  logic          out_of_range;
  logic          accept;
  logic          fetch_exc;
  logic [1:0]    fetch_code;
  logic [31:0]   fetch_inst;

  assign idx          = addr[AW+1:2];
  assign misaligned   = |addr[1:0];
  assign out_of_range = (addr >> (AW + 2)) != 32'd0;

  assign ready  = ~flush & ~rst & ((state == IDLE) | (state == RESP));
  assign accept = req & ready;

  // Misalignment outranks range; a faulting fetch returns a nop instead of memory data.
  always_comb begin
    fetch_exc  = 1'b0;
    fetch_code = 2'b00;
    fetch_inst = mem[idx];
    if (misaligned) begin
      fetch_exc  = 1'b1;
      fetch_code = 2'b01;
      fetch_inst = 32'h0000_0000;
    end else if (out_of_range) begin
      fetch_exc  = 1'b1;
      fetch_code = 2'b10;
      fetch_inst = 32'h0000_0000;
    end
  end

  // Program load; the fetch path reads the pre-write word, so same-edge collisions are read-first.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      valid    <= 1'b0;
      inst     <= 32'h0000_0000;
      exc      <= 1'b0;
      exc_code <= 2'b00;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= 3'd0;
      valid <= 1'b0;
    end else if (accept) begin
      inst     <= fetch_inst;
      exc      <= fetch_exc;
      exc_code <= fetch_code;
      if (WAIT_CYC == 0) begin
        state <= RESP;
        valid <= 1'b1;
      end else begin
        state <= WAIT;
        cnt   <= CNT_LOAD;
        valid <= 1'b0;
      end
    end else begin
      case (state)
        WAIT: begin
          if (cnt == 3'd0) begin
            state <= RESP;
            valid <= 1'b1;
          end else begin
            cnt   <= cnt - 3'd1;
            valid <= 1'b0;
          end
        end
        RESP: begin
          state <= IDLE;
          valid <= 1'b0;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
